shift_add_mul: RTL and testbench

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

---
 rtl/shift_add_mul.sv | 110 +++++++++++
 tb/tb_shift_add_mul.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier: one N-bit ripple-carry adder,
// N add/shift steps per product, result latched into p on the last step.

module rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module shift_add_mul #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  m;
    logic [N-1:0]  acc;
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;

    logic [N-1:0]  add_s;
    logic          add_c;
    logic [N-1:0]  sel_s;
    logic          sel_c;
    logic [N-1:0]  nxt_acc;
    logic [N-1:0]  nxt_q;

    rca #(.N(N)) u_rca (
        .a    (acc),
        .b    (m),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    // Carry lands in the top bit of the accumulator after the right shift.
    always_comb begin
        sel_s   = q[0] ? add_s : acc;
        sel_c   = q[0] ? add_c : 1'b0;
        nxt_acc = {sel_c, sel_s[N-1:1]};
        nxt_q   = {sel_s[0], q[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= nxt_acc;
                    q   <= nxt_q;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        p     <= {nxt_acc, nxt_q};
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul (N=4): hand-computed products, latency,
// start-ignore, mid-run reset, back-to-back issue and an exhaustive sweep.

module tb_shift_add_mul;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] last_p = '0;

    shift_add_mul #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One product from IDLE: drives start for one cycle, checks busy length,
    // latency, p hold during RUN, the result and a one-cycle done pulse.
    task automatic do_mul(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        int busy_cnt;
        int k;
        exp_q.push_back(8'(x) * 8'(y));
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_hold"}, 16'(p), 16'(last_p));
        busy_cnt = 0;
        k        = 0;
        while (!done && k < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 16'(done), 16'd1);
        check({tag, "_lat"}, 16'(k), 16'(N));
        check({tag, "_busy"}, 16'(busy_cnt), 16'(N));
        check({tag, "_p"}, 16'(p), 16'(exp_q.pop_front()));
        last_p = p;
        @(negedge clk);
        check({tag, "_pulse"}, 16'(done), 16'd0);
    endtask

    initial begin
        int pulses;
        int first_i;
        int prev_i;

        rst   = 1'b1;
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_p", 16'(p), 16'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 16'(busy), 16'd0);

        do_mul(4'hF, 4'hF, "ff");
        check("ff_const", 16'(last_p), 16'h00E1);
        do_mul(4'h3, 4'h5, "m35");
        check("m35_const", 16'(last_p), 16'h000F);
        do_mul(4'h0, 4'hB, "m0b");
        check("m0b_const", 16'(last_p), 16'h0000);
        do_mul(4'h8, 4'h1, "m81");
        check("m81_const", 16'(last_p), 16'h0008);

        // start re-asserted during RUN must be dropped
        start = 1'b1;
        a     = 4'h7;
        b     = 4'h6;
        @(negedge clk);
        a = 4'h1;
        b = 4'h1;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("ign_pulses", 16'(pulses), 16'd1);
        check("ign_p", 16'(p), 16'h002A);
        check("ign_busy", 16'(busy), 16'd0);
        last_p = p;

        // reset in the second RUN cycle abandons the product
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_done", 16'(done), 16'd0);
        check("mid_rst_p", 16'(p), 16'd0);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("mid_rst_nopulse", 16'(pulses), 16'd0);
        last_p = '0;
        do_mul(4'h2, 4'h3, "m23");
        check("m23_const", 16'(last_p), 16'h0006);

        // start held high: done every N+2 cycles
        start   = 1'b1;
        a       = 4'h9;
        b       = 4'hA;
        pulses  = 0;
        first_i = -1;
        prev_i  = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("b2b_p", 16'(p), 16'h005A);
                if (first_i < 0) first_i = i;
                else check("b2b_gap", 16'(i - prev_i), 16'(N + 2));
                prev_i = i;
            end
        end
        start = 1'b0;
        check("b2b_first", 16'(first_i), 16'(N + 1));
        check("b2b_count", 16'(pulses), 16'd5);
        repeat (N + 2) @(negedge clk);
        last_p = p;

        // exhaustive sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_mul(4'(x), 4'(y), "sweep");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
